// File: rtl/instruction_fetch_sequencer_if.sv
// instruction_fetch_sequencer_if: control, memory and decoder signals of the fetch sequencer
interface instruction_fetch_sequencer_if;
   logic        start;
   logic [31:0] start_pc;
   logic        stop;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_valid;
   logic [31:0] mem_data;
   logic        DOR;
   logic        ack_from_next;
   logic [31:0] data_out;
   logic [31:0] pc_out;
   logic        busy;
   logic        halted;
   logic [15:0] fetch_count;
   modport master (
      output start, start_pc, stop, mem_valid, mem_data, ack_from_next,
      input  mem_req, mem_addr, DOR, data_out, pc_out, busy, halted, fetch_count
   );
   modport slave (
      input  start, start_pc, stop, mem_valid, mem_data, ack_from_next,
      output mem_req, mem_addr, DOR, data_out, pc_out, busy, halted, fetch_count
   );
endinterface

// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: fetches words from memory into a 2-entry buffer for the decoder
module instruction_fetch_sequencer #(
   parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF,
   parameter logic [31:0] PC_STEP   = 32'd4
) (
   input logic clk,
   input logic reset,
   instruction_fetch_sequencer_if.slave bus
);
   typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_HALT} state_t;
   state_t      state;
   logic [31:0] pc;
   logic        stop_seen;
   logic        ack_prev;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        halted;
   logic [15:0] fetch_count;
   logic [31:0] fifo_word [2];
   logic [31:0] fifo_pc   [2];
   logic        head;
   logic [1:0]  count;
   logic        tail;
   logic        is_halt;
   logic        push;
   logic        pop;
   assign is_halt = bus.mem_data == HALT_WORD;
   assign push    = state == F_WAIT && bus.mem_valid && !is_halt;
   assign pop     = bus.ack_from_next && !ack_prev && count != 2'd0;
   assign tail    = head ^ count[0];
   // fetch sequencing: one outstanding access at a time, only issued when the buffer has room
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= F_IDLE;
         pc          <= '0;
         stop_seen   <= 1'b0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         case (state)
            F_IDLE, F_HALT: if (bus.start) begin
               pc          <= bus.start_pc;
               fetch_count <= '0;
               halted      <= 1'b0;
               state       <= F_REQ;
            end
            F_REQ: if (bus.stop) begin
               state <= F_IDLE;
            end else if (count != 2'd2) begin
               mem_req  <= 1'b1;
               mem_addr <= pc;
               state    <= F_WAIT;
            end
            F_WAIT: begin
               stop_seen <= stop_seen | bus.stop;
               if (bus.mem_valid) begin
                  mem_req   <= 1'b0;
                  mem_addr  <= '0;
                  stop_seen <= 1'b0;
                  if (is_halt) begin
                     halted <= 1'b1;
                     state  <= F_HALT;
                  end else begin
                     pc          <= pc + PC_STEP;
                     fetch_count <= fetch_count + 16'd1;
                     state       <= (stop_seen | bus.stop) ? F_IDLE : F_REQ;
                  end
               end
            end
         endcase
      end
   end
   // two-entry word/pc buffer; pops only on a fresh ack edge so a held ack consumes one word
   always_ff @(posedge clk) begin
      if (reset) begin
         head     <= 1'b0;
         count    <= 2'd0;
         ack_prev <= 1'b0;
      end else begin
         if (push) begin
            fifo_word[tail] <= bus.mem_data;
            fifo_pc[tail]   <= pc;
         end
         if (pop) head <= ~head;
         count    <= count + 2'(push) - 2'(pop);
         ack_prev <= bus.ack_from_next;
      end
   end
   assign bus.mem_req     = mem_req;
   assign bus.mem_addr    = mem_addr;
   assign bus.DOR         = count != 2'd0;
   assign bus.data_out    = count != 2'd0 ? fifo_word[head] : '0;
   assign bus.pc_out      = count != 2'd0 ? fifo_pc[head] : '0;
   assign bus.busy        = state == F_REQ || state == F_WAIT || count != 2'd0;
   assign bus.halted      = halted;
   assign bus.fetch_count = fetch_count;
endmodule
